// File: rtl/gate_truth_sweeper.sv
`default_nettype none
// ============================================================================
// Module      : gate_truth_sweeper
// Description : Self-test engine for a combinational gate. It walks every input
//               vector, holds each one for SETTLE cycles, samples the gate
//               output and compares it with the selected logic function.
//               Reports a saturating mismatch count, the first failing vector
//               and pass/fail.
// Revision    : 1.0 - initial release
// ============================================================================
module gate_truth_sweeper #(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1,
    parameter int CNT_W  = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       mode,
    output logic [N_IN-1:0]  dut_in,
    input  logic             dut_y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             bad_mode,
    output logic [CNT_W-1:0] err_count,
    output logic             first_fail_vld,
    output logic [N_IN-1:0]  first_fail_vec
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_DRIVE = 2'd1;
    localparam logic [1:0] c_CHECK = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    // vec carries one spare bit so the last vector is detected without wrapping
    localparam logic [N_IN:0]    c_LAST    = {1'b0, {N_IN{1'b1}}};
    localparam logic [3:0]       c_SETTLE  = 4'(SETTLE);
    localparam logic [CNT_W-1:0] c_ERR_MAX = {CNT_W{1'b1}};

    logic [1:0]       state_q,     state_d;
    logic [N_IN:0]    vec_q,       vec_d;
    logic [3:0]       settle_q,    settle_d;
    logic [2:0]       mode_q,      mode_d;
    logic [CNT_W-1:0] err_q,       err_d;
    logic             ffv_q,       ffv_d;
    logic [N_IN-1:0]  ffvec_q,     ffvec_d;
    logic             pass_q,      pass_d;
    logic             bad_mode_q,  bad_mode_d;
    logic             busy_q,      busy_d;
    logic             done_q,      done_d;
    logic [N_IN-1:0]  dut_in_q,    dut_in_d;

    logic [N_IN-1:0]  w_vec;
    logic             w_exp;

    // Expected gate output for the current vector under the latched mode
    always_comb begin
        w_vec = vec_q[N_IN-1:0];
        case (mode_q)
            3'b000:  w_exp = &w_vec;
            3'b001:  w_exp = ~&w_vec;
            3'b010:  w_exp = |w_vec;
            3'b011:  w_exp = ~|w_vec;
            3'b100:  w_exp = ^w_vec;
            3'b101:  w_exp = ~^w_vec;
            default: w_exp = 1'b0;
        endcase
    end

    // Sweep sequencing, result accumulation and registered output values
    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        settle_d   = settle_q;
        mode_d     = mode_q;
        err_d      = err_q;
        ffv_d      = ffv_q;
        ffvec_d    = ffvec_q;
        pass_d     = pass_q;
        bad_mode_d = bad_mode_q;

        case (state_q)
            c_IDLE: begin
                if (start) begin
                    err_d   = '0;
                    ffv_d   = 1'b0;
                    ffvec_d = '0;
                    pass_d  = 1'b0;
                    if (mode <= 3'b101) begin
                        mode_d     = mode;
                        vec_d      = '0;
                        settle_d   = c_SETTLE;
                        bad_mode_d = 1'b0;
                        state_d    = c_DRIVE;
                    end else begin
                        bad_mode_d = 1'b1;
                        state_d    = c_DONE;
                    end
                end
            end
            c_DRIVE: begin
                if (settle_q <= 4'd1) begin
                    state_d = c_CHECK;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end
            c_CHECK: begin
                if (dut_y != w_exp) begin
                    if (err_q != c_ERR_MAX) begin
                        err_d = err_q + 1'b1;
                    end
                    if (!ffv_q) begin
                        ffv_d   = 1'b1;
                        ffvec_d = w_vec;
                    end
                end
                if (vec_q == c_LAST) begin
                    state_d = c_DONE;
                end else begin
                    vec_d    = vec_q + 1'b1;
                    settle_d = c_SETTLE;
                    state_d  = c_DRIVE;
                end
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase

        // Outputs follow the next state so they line up with it when registered
        busy_d   = (state_d == c_DRIVE) || (state_d == c_CHECK);
        done_d   = (state_d == c_DONE);
        dut_in_d = busy_d ? vec_d[N_IN-1:0] : '0;
        if (state_d == c_DONE) begin
            pass_d = (err_d == '0) && !bad_mode_d;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= c_IDLE;
            vec_q      <= '0;
            settle_q   <= '0;
            mode_q     <= '0;
            err_q      <= '0;
            ffv_q      <= 1'b0;
            ffvec_q    <= '0;
            pass_q     <= 1'b0;
            bad_mode_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dut_in_q   <= '0;
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            settle_q   <= settle_d;
            mode_q     <= mode_d;
            err_q      <= err_d;
            ffv_q      <= ffv_d;
            ffvec_q    <= ffvec_d;
            pass_q     <= pass_d;
            bad_mode_q <= bad_mode_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            dut_in_q   <= dut_in_d;
        end
    end

    assign dut_in         = dut_in_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign bad_mode       = bad_mode_q;
    assign err_count      = err_q;
    assign first_fail_vld = ffv_q;
    assign first_fail_vec = ffvec_q;

endmodule
`default_nettype wire

// File: tb/tb_gate_truth_sweeper.sv
`default_nettype none
// ============================================================================
// Module      : tb_gate_truth_sweeper
// Description : Self-checking bench for gate_truth_sweeper (3 inputs, settle 2,
//               3-bit saturating counter) against a cycle-indexed reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gate_truth_sweeper;

    localparam int N   = 3;
    localparam int S   = 2;
    localparam int CW  = 3;
    localparam int LEN = (1 << N) * (S + 1);
    localparam int EMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [2:0]    mode = 3'd0;
    logic [N-1:0]  dut_in;
    logic          dut_y;
    logic          busy, done, pass, bad_mode, first_fail_vld;
    logic [CW-1:0] err_count;
    logic [N-1:0]  first_fail_vec;

    logic [7:0]    resp = 8'h00;     // truth table of the simulated gate
    bit            chk_en = 1'b0;
    int            total = 0;
    int            bad = 0;

    // reference state: m_t = cycles since an accepted start (0 = idle)
    int            m_t = 0;
    bit            m_bp = 1'b0;      // done cycle after an invalid-mode start
    bit            m_bad = 1'b0;
    bit            m_cmp = 1'b0;     // a full sweep has completed
    int            m_n = 0;          // vectors whose results are visible
    logic [2:0]    m_mode = 3'd0;
    logic [7:0]    m_resp = 8'h00;

    gate_truth_sweeper #(.N_IN(N), .SETTLE(S), .CNT_W(CW)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .mode           (mode),
        .dut_in         (dut_in),
        .dut_y          (dut_y),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .bad_mode       (bad_mode),
        .err_count      (err_count),
        .first_fail_vld (first_fail_vld),
        .first_fail_vec (first_fail_vec)
    );

    assign dut_y = resp[dut_in];

    always #5 clk = ~clk;

    function automatic logic gate_fn(input logic [2:0] md, input logic [2:0] v);
        case (md)
            3'd0:    return &v;
            3'd1:    return ~&v;
            3'd2:    return |v;
            3'd3:    return ~|v;
            3'd4:    return ^v;
            3'd5:    return ~^v;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [7:0] tbl_of(input logic [2:0] md);
        logic [7:0] t;
        for (int v = 0; v < 8; v++) t[v] = gate_fn(md, 3'(v));
        return t;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference timeline: what the sweep must look like cycle by cycle
    always @(posedge clk) begin
        if (rst) begin
            m_t <= 0; m_bp <= 1'b0; m_bad <= 1'b0; m_cmp <= 1'b0; m_n <= 0;
        end else if (m_t != 0 && m_t <= LEN) begin
            m_t <= m_t + 1;
            m_n <= m_t / (S + 1);
            if (m_t == LEN) m_cmp <= 1'b1;
        end else if (m_t == LEN + 1 || m_bp) begin
            m_t  <= 0;
            m_bp <= 1'b0;
        end else if (start) begin
            m_n    <= 0;
            m_cmp  <= 1'b0;
            m_mode <= mode;
            m_resp <= resp;
            if (mode <= 3'd5) begin
                m_t   <= 1;
                m_bad <= 1'b0;
            end else begin
                m_bp  <= 1'b1;
                m_bad <= 1'b1;
            end
        end
    end

    // Compare every DUT output with the reference each cycle
    always @(negedge clk) begin : cmp
        bit         e_busy, e_done, e_ffv, e_pass;
        int         e_in, e_err, e_vec;
        if (chk_en) begin
            e_busy = (m_t >= 1) && (m_t <= LEN);
            e_done = (m_t == LEN + 1) || m_bp;
            e_in   = e_busy ? (m_t - 1) / (S + 1) : 0;
            e_err = 0; e_ffv = 1'b0; e_vec = 0;
            for (int v = 0; v < m_n; v++) begin
                if (m_resp[v] != gate_fn(m_mode, 3'(v))) begin
                    if (!e_ffv) begin e_ffv = 1'b1; e_vec = v; end
                    e_err++;
                end
            end
            if (e_err > EMAX) e_err = EMAX;
            e_pass = m_cmp && (e_err == 0) && !m_bad;
            check("busy", 32'(busy), 32'(e_busy));
            check("done", 32'(done), 32'(e_done));
            check("dut_in", 32'(dut_in), e_in);
            check("err_count", 32'(err_count), e_err);
            check("ff_vld", 32'(first_fail_vld), 32'(e_ffv));
            check("ff_vec", 32'(first_fail_vec), e_vec);
            check("pass", 32'(pass), 32'(e_pass));
            check("bad_mode", 32'(bad_mode), 32'(m_bad));
        end
    end

    // One sweep: start, stray starts and mode changes while active, optional reset
    task automatic run_sweep(input logic [2:0] md, input logic [7:0] tbl,
                             input int rst_at, output int dcyc);
        int n;
        bit fin;
        @(negedge clk);
        resp = tbl; mode = md; start = 1'b1;
        dcyc = 0; n = 0; fin = 1'b0;
        while (!fin && n < 60) begin
            @(negedge clk);
            n++;
            if (rst) begin
                rst = 1'b0; fin = 1'b1;
            end else if (done) begin
                dcyc = n; fin = 1'b1;
            end else if (n == rst_at) begin
                rst = 1'b1;
            end
            start = !fin && !rst && (m_t != 0 || m_bp) &&
                    (n == 4 || $urandom_range(0, 3) == 0);
            if (!fin) mode = 3'($urandom_range(0, 7));
        end
        start = 1'b0;
        if (!fin) check("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int d;
        logic [7:0] t;
        logic [2:0] md;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("rst_busy", 32'(busy), 0);
        check("rst_dut_in", 32'(dut_in), 0);
        check("rst_err", 32'(err_count), 0);
        rst = 1'b0;

        // ideal NAND
        run_sweep(3'd1, tbl_of(3'd1), 0, d);
        check("nand_done_cyc", d, 25);
        check("nand_pass", 32'(pass), 1);
        check("nand_err", 32'(err_count), 0);
        check("nand_ffv", 32'(first_fail_vld), 0);
        // AND with output stuck at 1
        run_sweep(3'd0, 8'hFF, 0, d);
        check("stuck_err", 32'(err_count), 7);
        check("stuck_ffvec", 32'(first_fail_vec), 0);
        check("stuck_ffv", 32'(first_fail_vld), 1);
        check("stuck_pass", 32'(pass), 0);
        // XOR expected, gate computes OR
        run_sweep(3'd4, 8'hFE, 0, d);
        check("xor_or_err", 32'(err_count), 3);
        check("xor_or_ffvec", 32'(first_fail_vec), 3);
        check("xor_or_done_cyc", d, 25);
        // invalid mode
        run_sweep(3'd6, 8'h00, 0, d);
        check("badm_done_cyc", d, 1);
        check("badm_flag", 32'(bad_mode), 1);
        check("badm_pass", 32'(pass), 0);
        check("badm_busy", 32'(busy), 0);
        // XNOR expected, gate inverted: every vector fails, counter saturates
        run_sweep(3'd5, 8'h96, 0, d);
        check("sat_err", 32'(err_count), 7);
        check("sat_ffvec", 32'(first_fail_vec), 0);
        // reset in the middle of a sweep, then a clean sweep
        run_sweep(3'd1, tbl_of(3'd1), 5, d);
        check("abort_no_done", d, 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_err", 32'(err_count), 0);
        run_sweep(3'd1, tbl_of(3'd1), 0, d);
        check("after_abort_pass", 32'(pass), 1);

        // randomized sweeps
        for (int i = 0; i < 30; i++) begin
            md = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 4))
                0: t = tbl_of(md);
                1: t = 8'($urandom);
                2: t = ~tbl_of(md);
                3: t = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
                default: begin
                    t = tbl_of(md);
                    t[$urandom_range(0, 7)] ^= 1'b1;
                end
            endcase
            run_sweep(md, t, ($urandom_range(0, 5) == 0) ? $urandom_range(1, 24) : 0, d);
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
